// File: rtl/gate_share_arbiter.sv
// Four requesters time-share one WIDTH-bit inverter through a round-robin arbiter
// and a one-deep result register. Define GATE_SHARE_STATS_EN to add the txn_count port.
module gate_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    output logic [3:0]           gnt,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_id,
    input  logic                 out_ready
`ifdef GATE_SHARE_STATS_EN
    ,
    output logic [15:0]          txn_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] gnt_id;
    logic       gnt_any;
    logic       slot;

    always_comb begin
        gnt       = '0;
        gnt_id    = ptr;
        gnt_any   = 1'b0;
        state_nxt = state;
        slot      = (state == EMPTY) || out_ready;
        // Scan from the far end so the requester nearest ptr overwrites and wins.
        if (!rst && slot) begin
            for (int k = 3; k >= 0; k--) begin
                if (req[ptr + 2'(k)]) begin
                    gnt_id  = ptr + 2'(k);
                    gnt_any = 1'b1;
                end
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
        case (state)
            EMPTY:   if (gnt_any) state_nxt = FULL;
            FULL:    if (out_ready && !gnt_any) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= 2'd0;
            out_data <= '0;
            out_id   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                ptr      <= gnt_id + 2'd1;
                out_data <= ~req_data[gnt_id*WIDTH +: WIDTH];
                out_id   <= gnt_id;
            end
        end
    end

    assign out_valid = (state == FULL);

`ifdef GATE_SHARE_STATS_EN
    logic [15:0] txn_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            txn_cnt <= 16'd0;
        else if (out_valid && out_ready && txn_cnt != 16'hFFFF)
            txn_cnt <= txn_cnt + 16'd1;
    end

    assign txn_count = txn_cnt;
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Scoreboard bench for gate_share_arbiter: a reference model predicts gnt each cycle
// and queues expected results, which are popped when the DUT completes them.
module tb_gate_share_arbiter;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [3:0]     gnt;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ready;
`ifdef GATE_SHARE_STATS_EN
    logic [15:0]    txn_count;
`endif

    gate_share_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef GATE_SHARE_STATS_EN
        ,
        .txn_count (txn_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         m_ptr;
    bit         m_full;
    int         m_cnt;
    int         n_checks;
    int         n_fail;
    logic [3:0] last_gnt;

    // One clock of stimulus: predict and check gnt before the edge, update the
    // model at the edge, then check the result register just after it.
    task automatic drive_cycle(input logic r, input logic [3:0] rq,
                               input logic [4*W-1:0] d, input logic rdy);
        logic [3:0] exp_g;
        int         exp_id;
        bit         found;
        exp_t       e;
        rst = r; req = rq; req_data = d; out_ready = rdy;
        #2;
        exp_g = 4'b0; found = 0; exp_id = 0;
        if (!r && (!m_full || rdy))
            for (int k = 0; k < 4; k++)
                if (!found && rq[(m_ptr + k) % 4]) begin
                    found  = 1;
                    exp_id = (m_ptr + k) % 4;
                end
        if (found) exp_g[exp_id] = 1'b1;
        last_gnt = gnt;
        n_checks++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL gnt: got %b expected %b (req=%b rdy=%b rst=%b)", gnt, exp_g, rq, rdy, r);
        end
        @(posedge clk);
        if (r) begin
            m_full = 0; m_ptr = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            if (m_full && rdy) begin
                void'(exp_q.pop_front());
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
            if (found) begin
                e.id   = 2'(exp_id);
                e.data = ~d[exp_id*W +: W];
                exp_q.push_back(e);
                m_ptr  = (exp_id + 1) % 4;
                m_full = 1;
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
        #1;
        n_checks++;
        if (out_valid !== m_full) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_full);
        end
        if (m_full && exp_q.size() > 0) begin
            n_checks++;
            if (out_data !== exp_q[0].data || out_id !== exp_q[0].id) begin
                n_fail++;
                $display("FAIL result: got id=%0d data=%h expected id=%0d data=%h",
                         out_id, out_data, exp_q[0].id, exp_q[0].data);
            end
        end
        if (r) begin
            n_checks++;
            if (out_data !== '0 || out_id !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_regs: got id=%0d data=%h expected 0/00", out_id, out_data);
            end
        end
`ifdef GATE_SHARE_STATS_EN
        n_checks++;
        if (txn_count !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL txn_count: got %0d expected %0d", txn_count, m_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1);
        drive_cycle(1'b1, 4'b1111, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        drive_cycle(1'b0, 4'b0001, 32'h0000_00A5, 1'b1);
        n_checks++;
        if (last_gnt !== 4'b0001 || out_valid !== 1'b1 || out_data !== 8'h5A || out_id !== 2'd0) begin
            n_fail++;
            $display("FAIL basic: got gnt=%b v=%b data=%h id=%0d expected 0001/1/5a/0",
                     last_gnt, out_valid, out_data, out_id);
        end
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 4'b1111, 32'h4433_2211, 1'b1);
            n_checks++;
            if (last_gnt !== exp_seq[i] || out_id !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got gnt=%b id=%0d expected %b/%0d",
                         i, last_gnt, out_id, exp_seq[i], i % 4);
            end
        end
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_data;
        logic [1:0]   held_id;
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        drive_cycle(1'b0, 4'b0001, 32'h0000_003C, 1'b0);
        held_data = out_data;
        held_id   = out_id;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 4'b0100, 32'h0077_0000, 1'b0);
            n_checks++;
            if (last_gnt !== 4'b0000 || out_data !== held_data || out_id !== held_id) begin
                n_fail++;
                $display("FAIL hold[%0d]: got gnt=%b data=%h id=%0d expected 0000/%h/%0d",
                         i, last_gnt, out_data, out_id, held_data, held_id);
            end
        end
        drive_cycle(1'b0, 4'b0100, 32'h0077_0000, 1'b1);
        n_checks++;
        if (last_gnt !== 4'b0100 || out_data !== 8'h88 || out_id !== 2'd2) begin
            n_fail++;
            $display("FAIL release: got gnt=%b data=%h id=%0d expected 0100/88/2",
                     last_gnt, out_data, out_id);
        end
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_ptr_skip();
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        drive_cycle(1'b0, 4'b0010, 32'h0000_1100, 1'b1);
        drive_cycle(1'b0, 4'b1010, 32'hF000_0F00, 1'b1);
        n_checks++;
        if (last_gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL skip_first: got %b expected 1000", last_gnt);
        end
        drive_cycle(1'b0, 4'b1010, 32'hF000_0F00, 1'b1);
        n_checks++;
        if (last_gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL skip_second: got %b expected 0010", last_gnt);
        end
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        drive_cycle(1'b0, 4'b0010, 32'h0000_5500, 1'b0);
        drive_cycle(1'b0, 4'b0000, '0, 1'b0);
        drive_cycle(1'b1, 4'b0000, '0, 1'b0);
        drive_cycle(1'b0, 4'b1000, 32'hC300_0000, 1'b1);
        n_checks++;
        if (last_gnt !== 4'b1000 || out_id !== 2'd3 || out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_mid: got gnt=%b id=%0d data=%h expected 1000/3/3c",
                     last_gnt, out_id, out_data);
        end
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            drive_cycle(($urandom_range(0, 49) == 0), 4'($urandom), $urandom,
                        ($urandom_range(0, 2) != 0));
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
    endtask

`ifdef GATE_SHARE_STATS_EN
    task automatic test_stats();
        drive_cycle(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 4'b0001, 32'h0000_0011, 1'b1);
        drive_cycle(1'b0, 4'b0000, '0, 1'b1);
        n_checks++;
        if (txn_count !== 16'd10) begin
            n_fail++;
            $display("FAIL stats_10: got %0d expected 10", txn_count);
        end
        for (int i = 0; i < 65540; i++) drive_cycle(1'b0, 4'b0001, 32'h0000_0011, 1'b1);
        n_checks++;
        if (txn_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_sat: got %h expected ffff", txn_count);
        end
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        m_ptr = 0; m_full = 0; m_cnt = 0;
        rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_ptr_skip();
        test_reset_mid();
        test_random();
`ifdef GATE_SHARE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_share_arbiter.md
GATE_SHARE_ARBITER -- requirements
Module: gate_share_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of each operand and result.
REQ-002 The block SHALL have a fixed requester count of 4 (ids 0..3), not parameterised.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port req  input  4  req[i] high means requester i has an operand pending.
REQ-006 Port req_data  input  4*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH].
REQ-007 Port gnt  output  4  one-hot or zero; gnt[i] high means requester i's operand is accepted at this edge.
REQ-008 Port out_valid  output  1  result register holds a valid result.
REQ-009 Port out_data  output  WIDTH  bitwise inversion of the accepted operand.
REQ-010 Port out_id  output  2  id of the requester that produced out_data.
REQ-011 Port out_ready  input  1  downstream accepts the result when out_valid and out_ready are both high at an edge.
REQ-012 Port txn_count  output  16  completed-result counter; present only per REQ-027.

Function
REQ-013 The block SHALL time-share one WIDTH-bit inverter between the 4 requesters; out_data SHALL equal ~req_data of the granted requester.
REQ-014 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 An accept slot SHALL exist when state is EMPTY, or when state is FULL and out_ready=1.
REQ-016 gnt SHALL be combinational from req, state, out_ready and the priority pointer; it SHALL be zero when no accept slot exists or req=0.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer ptr, then ptr+1, wrapping 3->0; first requester with req high is granted.
REQ-018 After a grant to requester i, ptr SHALL become (i+1) mod 4; with no grant, ptr SHALL be unchanged.
REQ-019 Latency SHALL be one cycle: an operand accepted at edge k appears on out_data/out_id with out_valid=1 after edge k.
REQ-020 Transitions: EMPTY + grant -> FULL; FULL + out_ready + grant -> FULL with new result (throughput 1/cycle); FULL + out_ready + no grant -> EMPTY; FULL + !out_ready -> FULL, out_data/out_id held stable.
REQ-021 Requesters SHALL hold req and req_data until gnt; dropping req before gnt SHALL be legal and SHALL not corrupt state.
REQ-022 gnt SHALL never have more than one bit set; a requester never gets a grant without req high.

Reset
REQ-023 While rst is high at an edge: state -> EMPTY, out_valid=0, out_data=0, out_id=0, ptr=0.
REQ-024 gnt SHALL be 0 during any cycle with rst high.
REQ-025 Reset mid-operation SHALL discard any held result without presenting it; no out_valid in the cycle after reset deasserts.
REQ-026 txn_count, when present, SHALL reset to 0.

Configuration
REQ-027 Macro GATE_SHARE_STATS_EN: when defined, port txn_count exists and increments by 1 on each edge where out_valid and out_ready are both high, saturating at 16'hFFFF; when undefined, port and counter are absent and all other behaviour is identical.

Verification
REQ-028 Reset then req=4'b0001, req_data[7:0]=8'hA5, out_ready=1 -> gnt=0001 same cycle; next cycle out_valid=1, out_data=8'h5A, out_id=0.
REQ-029 req=4'b1111 held, out_ready=1, four cycles after reset -> grant order 0,1,2,3, then 0 again (wrap); out_id sequence 0,1,2,3.
REQ-030 FULL with out_ready=0 for 5 cycles, req=4'b0100 -> gnt=0 all 5 cycles, out_data/out_id stable; out_ready=1 -> gnt=0100 same cycle, new result next cycle.
REQ-031 req=4'b1010 after a grant to requester 1 (ptr=2) -> requester 3 granted next, then requester 1.
REQ-032 rst asserted for one cycle while out_valid=1 and out_ready=0 -> out_valid=0, ptr=0 afterwards; req=4'b1000 then granted requester 3 with out_id=3.
REQ-033 With GATE_SHARE_STATS_EN: 10 accepted results with out_ready=1 -> txn_count=10; counter preloaded near 16'hFFFF stays at 16'hFFFF after further completions.
